uart_fifo_ext: RTL and testbench

- Parametrised successor UART for the CPU peripheral bus: configurable data width, parity and stop bits, 16x oversampled RX with 3-sample majority vote, and RX/TX FIFOs with valid/ready handshakes.
- Detects false starts, parity errors, framing errors and RX overrun.
- Sits between the CPU I/O register block and the board UART pins.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_fifo_ext.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_fifo_ext.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Desc     : Shared state encoding, parity modes and RX FIFO entry layout
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_entry_t;

    // Caller masks unused upper bits so they cannot disturb the result.
    function automatic logic calc_parity(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Desc     : First-word-fall-through FIFO with wrap-bit pointers
// Revision : 1.0
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ext
// Desc     : Parametrised UART, 16x oversampled RX, RX/TX FIFOs
// Revision : 1.0
// ============================================================================
module uart_fifo_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OS_DIV     = CLK_FREQ / (BAUD_RATE * 16),
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx_serial,
    output logic       tx_serial,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       ovr_clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic [5:0] dbg_uart_state
);
    localparam int            CW         = $clog2(OS_DIV);
    localparam logic [CW-1:0] TICK_MAX   = CW'(OS_DIV - 1);
    localparam logic [7:0]    DMASK      = 8'(16'h00FF >> (8 - DATA_BITS));
    localparam logic [2:0]    LAST_DBIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_SBIT  = 3'(STOP_BITS - 1);
    localparam uart_state_t   AFTER_DATA = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;

    logic [CW-1:0] tick_cnt_q;
    logic          tick;
    logic          rx_meta_q, rx_sync_q;

    uart_state_t rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [3:0]  rx_s_q, rx_s_d, tx_s_q, tx_s_d;
    logic [2:0]  rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [1:0]  rx_smp_q, rx_smp_d;
    logic [7:0]  rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic        rx_perr_q, rx_perr_d, rx_ovr_q, rx_ovr_d;
    logic        tx_par_q, tx_par_d, tx_ser_q, tx_ser_d;
    logic        rx_maj, rx_push, rx_pop, rx_full, rx_empty;
    logic        tx_push, tx_pop, tx_load, tx_full, tx_empty;
    logic [7:0]  tx_head;
    rx_entry_t   rx_wr, rx_head;

    assign tick   = (tick_cnt_q == TICK_MAX);
    assign rx_maj = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_sync_q) |
                    (rx_smp_q[1] & rx_sync_q);
    assign rx_wr  = '{data: rx_sh_q, perr: rx_perr_q, ferr: ~rx_maj};
    assign rx_pop = rx_ready && !rx_empty;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_bit_d   = rx_bit_q;
        rx_smp_d   = rx_smp_q;
        rx_sh_d    = rx_sh_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        if (tick) begin
            rx_s_d = rx_s_q + 4'd1;
            if (rx_s_q == 4'd7) rx_smp_d[0] = rx_sync_q;
            if (rx_s_q == 4'd8) rx_smp_d[1] = rx_sync_q;
            case (rx_state_q)
                ST_IDLE: begin
                    rx_s_d = 4'd0;
                    if (!rx_sync_q) begin
                        rx_state_d = ST_START;
                        rx_bit_d   = 3'd0;
                        rx_sh_d    = 8'd0;
                        rx_perr_d  = 1'b0;
                    end
                end
                ST_START: begin
                    if (rx_s_q == 4'd9 && rx_maj) rx_state_d = ST_IDLE;
                    else if (rx_s_q == 4'd15)     rx_state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (rx_s_q == 4'd9) rx_sh_d[rx_bit_q] = rx_maj;
                    if (rx_s_q == 4'd15) begin
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_DBIT) rx_state_d = AFTER_DATA;
                    end
                end
                ST_PARITY: begin
                    if (rx_s_q == 4'd9)  rx_perr_d  = rx_maj ^ calc_parity(rx_sh_q, PARITY);
                    if (rx_s_q == 4'd15) rx_state_d = ST_STOP;
                end
                ST_STOP: begin
                    // Only the first stop bit is checked; return early to resync.
                    if (rx_s_q == 4'd9) begin
                        rx_push    = 1'b1;
                        rx_state_d = ST_IDLE;
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ovr_d = rx_ovr_q;
        if (ovr_clr) rx_ovr_d = 1'b0;
        if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        if (tick) begin
            tx_s_d = tx_s_q + 4'd1;
            case (tx_state_q)
                ST_IDLE: begin
                    tx_s_d  = 4'd0;
                    tx_load = !tx_empty;
                end
                ST_START: if (tx_s_q == 4'd15) tx_state_d = ST_DATA;
                ST_DATA: begin
                    if (tx_s_q == 4'd15) begin
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == LAST_DBIT) begin
                            tx_bit_d   = 3'd0;
                            tx_state_d = AFTER_DATA;
                        end
                    end
                end
                ST_PARITY: if (tx_s_q == 4'd15) tx_state_d = ST_STOP;
                ST_STOP: begin
                    if (tx_s_q == 4'd15) begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == LAST_SBIT) begin
                            tx_state_d = ST_IDLE;
                            tx_load    = !tx_empty;
                        end
                    end
                end
                default: tx_state_d = ST_IDLE;
            endcase
            // Back-to-back frames: the next start bit follows the last stop bit directly.
            if (tx_load) begin
                tx_state_d = ST_START;
                tx_s_d     = 4'd0;
                tx_bit_d   = 3'd0;
                tx_sh_d    = tx_head & DMASK;
                tx_par_d   = calc_parity(tx_head & DMASK, PARITY);
            end
        end
        case (tx_state_d)
            ST_START:  tx_ser_d = 1'b0;
            ST_DATA:   tx_ser_d = tx_sh_d[0];
            ST_PARITY: tx_ser_d = tx_par_d;
            default:   tx_ser_d = 1'b1;
        endcase
    end

    assign tx_pop  = tx_load;
    assign tx_push = tx_valid && tx_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_s_q     <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_smp_q   <= 2'b11;
            rx_sh_q    <= 8'd0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_s_q     <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_par_q   <= 1'b0;
            tx_ser_q   <= 1'b1;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            rx_meta_q  <= rx_serial;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_bit_q   <= rx_bit_d;
            rx_smp_q   <= rx_smp_d;
            rx_sh_q    <= rx_sh_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_ser_q   <= tx_ser_d;
        end
    end

    uart_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (rx_push),
        .wdata_i (rx_wr),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (tx_push),
        .wdata_i (tx_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign tx_serial      = tx_ser_q;
    assign rx_data        = rx_head.data;
    assign rx_perr        = rx_head.perr;
    assign rx_ferr        = rx_head.ferr;
    assign rx_valid       = !rx_empty;
    assign rx_overrun     = rx_ovr_q;
    assign tx_ready       = !tx_full;
    assign tx_busy        = !tx_empty || (tx_state_q != ST_IDLE);
    assign dbg_uart_state = {tx_state_q, rx_state_q};

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ext
// Desc     : Bench for uart_fifo_ext: 8N1 (depth 4) and 7E2 (depth 8) instances
// Revision : 1.0
// ============================================================================
module tb_uart_fifo_ext;
    localparam int OSD  = 4;
    localparam int BITC = 16 * OSD;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       loop_a, a_drv, a_rx_in, a_tx, a_perr, a_ferr, a_rv, a_rr, a_ovr, a_oclr;
    logic       a_tv, a_trdy, a_tbusy;
    logic [7:0] a_rd, a_td;
    logic [5:0] a_dbg;
    logic       b_drv, b_tx, b_perr, b_ferr, b_rv, b_rr, b_ovr, b_oclr, b_tv, b_trdy, b_tbusy;
    logic [7:0] b_rd, b_td;
    logic [5:0] b_dbg;

    assign a_rx_in = loop_a ? a_tx : a_drv;

    uart_fifo_ext #(.CLK_FREQ(50_000_000), .BAUD_RATE(9600), .OS_DIV(OSD), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .CLK(clk), .RST_N(rst_n), .rx_serial(a_rx_in), .tx_serial(a_tx), .rx_data(a_rd),
        .rx_perr(a_perr), .rx_ferr(a_ferr), .rx_valid(a_rv), .rx_ready(a_rr),
        .rx_overrun(a_ovr), .ovr_clr(a_oclr), .tx_data(a_td), .tx_valid(a_tv),
        .tx_ready(a_trdy), .tx_busy(a_tbusy), .dbg_uart_state(a_dbg));

    uart_fifo_ext #(.CLK_FREQ(50_000_000), .BAUD_RATE(9600), .OS_DIV(OSD), .DATA_BITS(7),
                    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u_b (
        .CLK(clk), .RST_N(rst_n), .rx_serial(b_drv), .tx_serial(b_tx), .rx_data(b_rd),
        .rx_perr(b_perr), .rx_ferr(b_ferr), .rx_valid(b_rv), .rx_ready(b_rr),
        .rx_overrun(b_ovr), .ovr_clr(b_oclr), .tx_data(b_td), .tx_valid(b_tv),
        .tx_ready(b_trdy), .tx_busy(b_tbusy), .dbg_uart_state(b_dbg));

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } ent_t;

    ent_t mq_a[$];
    ent_t mq_b[$];
    logic movr_a;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic par_bit(input logic [7:0] d, input int nbits, input int mode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        return (mode == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic logic line(input int sel);
        return (sel == 0) ? a_tx : b_tx;
    endfunction

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0) a_drv = v; else b_drv = v;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic drive_frame(input int sel, input logic [7:0] d, input int nbits,
                               input int mode, input bit bad_par, input logic stop_v);
        ent_t e;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
        if (mode != 0) drive_bit(sel, par_bit(d, nbits, mode) ^ bad_par);
        drive_bit(sel, stop_v);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
        e.d    = d & 8'((1 << nbits) - 1);
        e.perr = (mode != 0) && bad_par;
        e.ferr = !stop_v;
        if (sel == 0) begin
            if (mq_a.size() < 4) mq_a.push_back(e); else movr_a = 1'b1;
        end else begin
            mq_b.push_back(e);
        end
    endtask

    task automatic push_tx(input int sel, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!((sel == 0) ? a_trdy : b_trdy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) chk("tx_ready_wait", (sel == 0) ? a_trdy : b_trdy, 1);
        if (sel == 0) begin a_td = d; a_tv = 1'b1; end
        else          begin b_td = d; b_tv = 1'b1; end
        @(negedge clk);
        a_tv = 1'b0;
        b_tv = 1'b0;
    endtask

    task automatic pop_chk(input int sel, input string tag);
        int   t = 0;
        ent_t e;
        while (!((sel == 0) ? a_rv : b_rv) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, (sel == 0) ? a_rv : b_rv, 1);
        chk({tag, "_model_nonempty"}, ((sel == 0) ? mq_a.size() : mq_b.size()) > 0, 1);
        if (((sel == 0) ? mq_a.size() : mq_b.size()) == 0) return;
        e = (sel == 0) ? mq_a.pop_front() : mq_b.pop_front();
        chk({tag, "_data"}, (sel == 0) ? a_rd   : b_rd,   e.d);
        chk({tag, "_perr"}, (sel == 0) ? a_perr : b_perr, e.perr);
        chk({tag, "_ferr"}, (sel == 0) ? a_ferr : b_ferr, e.ferr);
        if (sel == 0) a_rr = 1'b1; else b_rr = 1'b1;
        @(negedge clk);
        a_rr = 1'b0;
        b_rr = 1'b0;
    endtask

    task automatic drain(input int sel, input string tag);
        while (((sel == 0) ? mq_a.size() : mq_b.size()) > 0) pop_chk(sel, tag);
        @(negedge clk);
        chk({tag, "_empty"}, (sel == 0) ? a_rv : b_rv, 0);
    endtask

    task automatic wait_fall(input int sel, input string tag);
        int t = 0;
        while (line(sel) !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_start_seen"}, line(sel), 0);
    endtask

    // Expected line built frame by frame, sampled mid-bit; the exact
    // boundary between frames is probed one cycle either side.
    task automatic check_tx(input int sel, input logic [7:0] d0, input logic [7:0] d1,
                            input int nfr, input int nbits, input int mode,
                            input int nstop, input string tag);
        logic exp_bits[$];
        logic [7:0] d;
        int flen = 1 + nbits + ((mode != 0) ? 1 : 0) + nstop;
        for (int f = 0; f < nfr; f++) begin
            d = (f == 0) ? d0 : d1;
            exp_bits.push_back(1'b0);
            for (int i = 0; i < nbits; i++) exp_bits.push_back(d[i]);
            if (mode != 0) exp_bits.push_back(par_bit(d, nbits, mode));
            for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
        end
        wait_fall(sel, tag);
        for (int c = 0; c < nfr * flen * BITC; c++) begin
            if (c % BITC == BITC / 2)
                chk($sformatf("%s_bit%0d", tag, c / BITC), line(sel), exp_bits[c / BITC]);
            if (nfr > 1 && c == flen * BITC - 1) chk({tag, "_last_stop"}, line(sel), 1);
            if (nfr > 1 && c == flen * BITC)     chk({tag, "_next_start"}, line(sel), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ent_t       e;
        logic [7:0] d0, d1;
        rst_n = 1'b0; loop_a = 1'b0; a_drv = 1'b1; a_rr = 1'b0; a_oclr = 1'b0;
        a_td = 8'd0; a_tv = 1'b0; b_drv = 1'b1; b_rr = 1'b0; b_oclr = 1'b0;
        b_td = 8'd0; b_tv = 1'b0; movr_a = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_serial", a_tx, 1);
        chk("rst_rx_valid", a_rv, 0);
        chk("rst_tx_ready", a_trdy, 1);
        chk("rst_tx_busy", a_tbusy, 0);
        chk("rst_overrun", a_ovr, 0);
        chk("rst_dbg", a_dbg, 0);
        chk("rst_b_tx_serial", b_tx, 1);
        chk("rst_b_dbg", b_dbg, 0);

        // 8N1 loopback, back-to-back frames
        loop_a = 1'b1;
        e.perr = 1'b0; e.ferr = 1'b0;
        e.d = 8'hA5; mq_a.push_back(e);
        e.d = 8'h3C; mq_a.push_back(e);
        fork
            check_tx(0, 8'hA5, 8'h3C, 2, 8, 0, 1, "tx8n1");
            begin push_tx(0, 8'hA5); push_tx(0, 8'h3C); end
        join
        drain(0, "loop_fixed");

        // Random loopback with concurrent consumer
        fork
            for (int i = 0; i < 12; i++) begin
                ent_t r;
                r.d = 8'($urandom); r.perr = 1'b0; r.ferr = 1'b0;
                mq_a.push_back(r);
                push_tx(0, r.d);
            end
            for (int i = 0; i < 12; i++) pop_chk(0, "loop_rand");
        join
        repeat (BITC) @(negedge clk);
        chk("loop_tx_idle", a_tbusy, 0);
        chk("loop_rx_empty", a_rv, 0);
        loop_a = 1'b0;

        // Glitch shorter than half a bit
        repeat (BITC) @(negedge clk);
        a_drv = 1'b0;
        repeat (4 * OSD) @(negedge clk);
        chk("glitch_in_start", a_dbg[2:0], 1);
        a_drv = 1'b1;
        repeat (3 * BITC) @(negedge clk);
        chk("glitch_rx_idle", a_dbg[2:0], 0);
        chk("glitch_no_valid", a_rv, 0);
        drive_frame(0, 8'h81, 8, 0, 0, 1'b1);
        drain(0, "after_glitch");

        // Framing error then a clean frame
        drive_frame(0, 8'hFF, 8, 0, 0, 1'b0);
        drive_frame(0, 8'h00, 8, 0, 0, 1'b1);
        drain(0, "framing");

        // Overrun on depth-4 FIFO
        for (int i = 1; i <= 5; i++) drive_frame(0, 8'(i), 8, 0, 0, 1'b1);
        chk("overrun_set", a_ovr, movr_a);
        drain(0, "overrun");
        chk("overrun_sticky", a_ovr, movr_a);
        a_oclr = 1'b1;
        @(negedge clk);
        a_oclr = 1'b0;
        movr_a = 1'b0;
        chk("overrun_clr", a_ovr, movr_a);

        // 7E2: directed parity cases then random frames
        drive_frame(1, 8'h55, 7, 1, 1, 1'b1);
        drive_frame(1, 8'h55, 7, 1, 0, 1'b1);
        drain(1, "par7e");
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 5; i++)
                drive_frame(1, 8'($urandom), 7, 1, bit'($urandom % 2), ($urandom % 4) != 0);
            drain(1, "rand7e");
        end
        chk("b_no_overrun", b_ovr, 0);
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        fork
            check_tx(1, d0, d1, 2, 7, 1, 2, "tx7e2");
            begin push_tx(1, d0); push_tx(1, d1); end
        join

        // Reset during data bit 3 of a frame
        fork
            push_tx(0, 8'hF0);
            begin
                wait_fall(0, "rstmid");
                repeat (4 * BITC + BITC / 2) @(negedge clk);
                chk("rstmid_bit3", a_tx, 0);
            end
        join
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx_serial", a_tx, 1);
        chk("rstmid_tx_busy", a_tbusy, 0);
        chk("rstmid_tx_ready", a_trdy, 1);
        mq_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fork
            check_tx(0, 8'h12, 8'h00, 1, 8, 0, 1, "tx_after_rst");
            push_tx(0, 8'h12);
        join
        repeat (BITC) @(negedge clk);
        chk("after_rst_idle", a_tbusy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
